// File: rtl/jelly2_rtos_wb_arbiter.sv
// jelly2_rtos_wb_arbiter
//   Round-robin arbiter that shares the RTOS accelerator's Wishbone register
//   port between NUM_MASTERS requesters, one transaction at a time.
//   The granted master index is forwarded on m_wb_id_o.
//   Optional forced completion of stalled transactions is enabled by
//   defining JELLY2_RTOS_WB_ARB_TIMEOUT_EN.

module jelly2_rtos_wb_arbiter #(
   parameter int unsigned                  NUM_MASTERS    = 3,
   parameter int unsigned                  WB_ADR_WIDTH   = 16,
   parameter int unsigned                  WB_DAT_WIDTH   = 32,
   parameter int unsigned                  WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
   parameter int unsigned                  ID_WIDTH       = 2,
   parameter int unsigned                  TIMEOUT_CYCLES = 256,
   parameter logic [WB_DAT_WIDTH-1:0]      TIMEOUT_DATA   = WB_DAT_WIDTH'(32'hDEAD_0BAD)
) (
   input  logic                                 wb_rst_i,
   input  logic                                 wb_clk_i,

   input  logic [NUM_MASTERS*WB_ADR_WIDTH-1:0]  s_wb_adr_i,
   input  logic [NUM_MASTERS*WB_DAT_WIDTH-1:0]  s_wb_dat_i,
   output logic [NUM_MASTERS*WB_DAT_WIDTH-1:0]  s_wb_dat_o,
   input  logic [NUM_MASTERS-1:0]               s_wb_we_i,
   input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  s_wb_sel_i,
   input  logic [NUM_MASTERS-1:0]               s_wb_stb_i,
   output logic [NUM_MASTERS-1:0]               s_wb_ack_o,

   output logic [WB_ADR_WIDTH-1:0]              m_wb_adr_o,
   output logic [WB_DAT_WIDTH-1:0]              m_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0]              m_wb_dat_i,
   output logic                                 m_wb_we_o,
   output logic [WB_SEL_WIDTH-1:0]              m_wb_sel_o,
   output logic                                 m_wb_stb_o,
   input  logic                                 m_wb_ack_i,
   output logic [ID_WIDTH-1:0]                  m_wb_id_o,

   output logic                                 timeout_o
);

   localparam int unsigned NM = NUM_MASTERS;
   localparam int unsigned AW = WB_ADR_WIDTH;
   localparam int unsigned DW = WB_DAT_WIDTH;
   localparam int unsigned SW = WB_SEL_WIDTH;
   localparam int unsigned ID_MIN = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   // Elaboration-time parameter sanity
   if (NUM_MASTERS < 1) begin : g_bad_num_masters
      $error("NUM_MASTERS must be at least 1");
   end
   if (ID_WIDTH < ID_MIN) begin : g_bad_id_width
      $error("ID_WIDTH too narrow for NUM_MASTERS");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              state;
   logic [ID_WIDTH-1:0] grant;
   logic [ID_WIDTH-1:0] last;
   logic [ID_WIDTH-1:0] rr_next;
   logic                busy;
   logic                stb_g;
   logic                tmo_fire;

   // First requester after 'prev' in circular order; nearest candidate wins
   function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NM-1:0]       req,
                                                   input logic [ID_WIDTH-1:0] prev);
      logic [ID_WIDTH-1:0] pick;
      int unsigned         idx;
      pick = prev;
      for (int unsigned k = NM; k > 0; k--) begin
         idx = (32'(prev) + k) % NM;
         if (req[idx]) begin
            pick = ID_WIDTH'(idx);
         end
      end
      return pick;
   endfunction

   // Round-robin candidate for the next arbitration cycle
   always_comb begin
      rr_next = rr_pick(s_wb_stb_i, last);
   end

   assign busy = (state == ST_BUSY);

   // Forward the granted master's request signals to the slave side
   always_comb begin
      m_wb_adr_o = s_wb_adr_i[0 +: AW];
      m_wb_dat_o = s_wb_dat_i[0 +: DW];
      m_wb_we_o  = s_wb_we_i[0];
      m_wb_sel_o = s_wb_sel_i[0 +: SW];
      stb_g      = s_wb_stb_i[0];
      for (int unsigned i = 1; i < NM; i++) begin
         if (grant == ID_WIDTH'(i)) begin
            m_wb_adr_o = s_wb_adr_i[i*AW +: AW];
            m_wb_dat_o = s_wb_dat_i[i*DW +: DW];
            m_wb_we_o  = s_wb_we_i[i];
            m_wb_sel_o = s_wb_sel_i[i*SW +: SW];
            stb_g      = s_wb_stb_i[i];
         end
      end
   end

`ifdef JELLY2_RTOS_WB_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] tmo_cnt;

   // A real ack in the same cycle takes precedence over the forced completion
   assign tmo_fire = busy && stb_g && !m_wb_ack_i
                     && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count BUSY cycles without ack; held at zero outside BUSY so entry starts at zero
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         tmo_cnt <= '0;
      end else if (!busy) begin
         tmo_cnt <= '0;
      end else if (!m_wb_ack_i) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end
`else
   assign tmo_fire = 1'b0;
`endif

   // Slave-side strobe is suppressed in IDLE (arbitration cycle) and on forced completion
   assign m_wb_stb_o = busy && stb_g && !tmo_fire;
   assign m_wb_id_o  = grant;
   assign timeout_o  = tmo_fire;

   // Ack routed only to the granted master; read data broadcast to every slot
   always_comb begin
      for (int unsigned i = 0; i < NM; i++) begin
         s_wb_ack_o[i] = busy && (grant == ID_WIDTH'(i)) && (m_wb_ack_i || tmo_fire);
         s_wb_dat_o[i*DW +: DW] = (tmo_fire && (grant == ID_WIDTH'(i))) ? TIMEOUT_DATA
                                                                         : m_wb_dat_i;
      end
   end

   // Arbitration state machine: grant in IDLE, release on ack, stb drop or timeout
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state <= ST_IDLE;
         grant <= '0;
         last  <= ID_WIDTH'(NM - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (|s_wb_stb_i) begin
                  grant <= rr_next;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (m_wb_ack_i || !stb_g || tmo_fire) begin
                  last  <= grant;
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jelly2_rtos_wb_arbiter.sv
// tb_jelly2_rtos_wb_arbiter
//   Scoreboard bench: each stimulus step pushes its expected acknowledge into
//   a queue; a monitor pops and compares whenever a master ack is presented.
//   A small slave model acks after a programmable number of BUSY cycles.

module tb_jelly2_rtos_wb_arbiter;

   localparam int unsigned NM = 3;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned IW = 2;
   localparam int unsigned TC = 16;

   logic                 wb_rst_i;
   logic                 wb_clk_i;
   logic [NM*AW-1:0]     s_wb_adr_i;
   logic [NM*DW-1:0]     s_wb_dat_i;
   logic [NM*DW-1:0]     s_wb_dat_o;
   logic [NM-1:0]        s_wb_we_i;
   logic [NM*SW-1:0]     s_wb_sel_i;
   logic [NM-1:0]        s_wb_stb_i;
   logic [NM-1:0]        s_wb_ack_o;
   logic [AW-1:0]        m_wb_adr_o;
   logic [DW-1:0]        m_wb_dat_o;
   logic [DW-1:0]        m_wb_dat_i;
   logic                 m_wb_we_o;
   logic [SW-1:0]        m_wb_sel_o;
   logic                 m_wb_stb_o;
   logic                 m_wb_ack_i;
   logic [IW-1:0]        m_wb_id_o;
   logic                 timeout_o;

   jelly2_rtos_wb_arbiter #(
      .NUM_MASTERS    (NM),
      .WB_ADR_WIDTH   (AW),
      .WB_DAT_WIDTH   (DW),
      .WB_SEL_WIDTH   (SW),
      .ID_WIDTH       (IW),
      .TIMEOUT_CYCLES (TC),
      .TIMEOUT_DATA   (32'hDEAD_0BAD)
   ) dut (
      .wb_rst_i   (wb_rst_i),
      .wb_clk_i   (wb_clk_i),
      .s_wb_adr_i (s_wb_adr_i),
      .s_wb_dat_i (s_wb_dat_i),
      .s_wb_dat_o (s_wb_dat_o),
      .s_wb_we_i  (s_wb_we_i),
      .s_wb_sel_i (s_wb_sel_i),
      .s_wb_stb_i (s_wb_stb_i),
      .s_wb_ack_o (s_wb_ack_o),
      .m_wb_adr_o (m_wb_adr_o),
      .m_wb_dat_o (m_wb_dat_o),
      .m_wb_dat_i (m_wb_dat_i),
      .m_wb_we_o  (m_wb_we_o),
      .m_wb_sel_o (m_wb_sel_o),
      .m_wb_stb_o (m_wb_stb_o),
      .m_wb_ack_i (m_wb_ack_i),
      .m_wb_id_o  (m_wb_id_o),
      .timeout_o  (timeout_o)
   );

   typedef struct {
      logic [NM-1:0] ack;
      logic [DW-1:0] dat;
      logic [IW-1:0] id;
      logic [AW-1:0] adr;
      logic          we;
      logic [DW-1:0] wdat;
      logic [SW-1:0] sel;
      logic          mstb;
      logic          tmo;
   } exp_t;

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;

   // Per-master request state: current transaction and remaining repeat count
   logic [AW-1:0] cur_adr [NM];
   logic          cur_we  [NM];
   logic [DW-1:0] cur_dat [NM];
   logic [SW-1:0] cur_sel [NM];
   int            rem     [NM];

   int            slave_lat;
   logic          slave_mute;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [NM-1:0] ack, input logic [DW-1:0] dat,
                           input logic [IW-1:0] id, input logic [AW-1:0] adr,
                           input logic we, input logic [DW-1:0] wdat,
                           input logic [SW-1:0] sel, input logic mstb, input logic tmo);
      exp_t e;
      e.ack = ack; e.dat = dat; e.id = id; e.adr = adr; e.we = we;
      e.wdat = wdat; e.sel = sel; e.mstb = mstb; e.tmo = tmo;
      sb.push_back(e);
   endtask

   task automatic issue(input int i, input logic [AW-1:0] adr, input logic we,
                        input logic [DW-1:0] dat, input logic [SW-1:0] sel, input int n);
      cur_adr[i] = adr;
      cur_we[i]  = we;
      cur_dat[i] = dat;
      cur_sel[i] = sel;
      rem[i]     = n;
   endtask

   // Wait (bounded) until all masters are done and the scoreboard drained
   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge wb_clk_i);
         if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: transactions still pending after 200 cycles (sb=%0d)", name, sb.size());
      end
   endtask

   // Bounded wait for the slave-side strobe to be presented
   task automatic wait_mstb(input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge wb_clk_i);
         if (m_wb_stb_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: m_wb_stb_o never asserted, got 0 required 1", name);
      end
   endtask

   initial begin
      wb_clk_i = 1'b0;
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   // Master driver: drops a request after its ack, re-requests while count remains
   initial begin
      logic [NM-1:0] seen;
      s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_we_i = '0; s_wb_sel_i = '0; s_wb_stb_i = '0;
      for (int i = 0; i < NM; i++) begin
         cur_adr[i] = '0; cur_we[i] = 1'b0; cur_dat[i] = '0; cur_sel[i] = '0; rem[i] = 0;
      end
      forever begin
         @(negedge wb_clk_i);
         seen = s_wb_ack_o;
         @(posedge wb_clk_i);
         #2;
         for (int i = 0; i < NM; i++) begin
            if (seen[i] && rem[i] > 0) rem[i]--;
            s_wb_stb_i[i]          = (rem[i] > 0);
            s_wb_we_i[i]           = cur_we[i];
            s_wb_adr_i[i*AW +: AW] = cur_adr[i];
            s_wb_dat_i[i*DW +: DW] = cur_dat[i];
            s_wb_sel_i[i*SW +: SW] = cur_sel[i];
         end
      end
   end

   // Slave model: ack in the slave_lat-th cycle the strobe is seen, data = {A5A5, adr}
   initial begin
      int scnt;
      scnt = 0;
      m_wb_ack_i = 1'b0;
      m_wb_dat_i = '0;
      forever begin
         @(posedge wb_clk_i);
         #1;
         if (!wb_rst_i || m_wb_ack_i) begin
            m_wb_ack_i = 1'b0;
            scnt = 0;
         end else if (m_wb_stb_o && !slave_mute) begin
            scnt++;
            if (scnt >= slave_lat) begin
               m_wb_ack_i = 1'b1;
               m_wb_dat_i = {16'hA5A5, m_wb_adr_o};
            end
         end else begin
            scnt = 0;
         end
      end
   end

   // Monitor: compare every presented ack against the scoreboard head
   initial begin
      exp_t e;
      int   slot;
      forever begin
         @(negedge wb_clk_i);
         if (|s_wb_ack_o) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ack: got ack=%b, required no ack", s_wb_ack_o);
            end else begin
               e = sb.pop_front();
               slot = 0;
               for (int k = 0; k < NM; k++) if (e.ack[k]) slot = k;
               chk("ack_vec",   64'(s_wb_ack_o), 64'(e.ack));
               chk("rd_data",   64'(s_wb_dat_o[slot*DW +: DW]), 64'(e.dat));
               chk("m_id",      64'(m_wb_id_o), 64'(e.id));
               chk("m_adr",     64'(m_wb_adr_o), 64'(e.adr));
               chk("m_we",      64'(m_wb_we_o), 64'(e.we));
               chk("m_sel",     64'(m_wb_sel_o), 64'(e.sel));
               chk("m_stb",     64'(m_wb_stb_o), 64'(e.mstb));
               chk("timeout_o", 64'(timeout_o), 64'(e.tmo));
               if (e.we) chk("m_wdat", 64'(m_wb_dat_o), 64'(e.wdat));
            end
         end else if (timeout_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL stray_timeout: got timeout_o=1 with no ack, required 0");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int n;
      wb_rst_i   = 1'b0;
      slave_lat  = 1;
      slave_mute = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      #3 wb_rst_i = 1'b1;

      // Idle after reset
      for (int c = 0; c < 10; c++) begin
         @(negedge wb_clk_i);
         chk("rst_ack",   64'(s_wb_ack_o), 64'd0);
         chk("rst_mstb",  64'(m_wb_stb_o), 64'd0);
         chk("rst_id",    64'(m_wb_id_o), 64'd0);
         chk("rst_tmo",   64'(timeout_o), 64'd0);
      end

      // Three simultaneous requesters, two transactions each, 1-cycle slave
      slave_lat = 1;
      push_exp(3'b001, 32'hA5A5_0A00, 2'd0, 16'h0A00, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      push_exp(3'b010, 32'hA5A5_0A01, 2'd1, 16'h0A01, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      push_exp(3'b100, 32'hA5A5_0A02, 2'd2, 16'h0A02, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      push_exp(3'b001, 32'hA5A5_0A00, 2'd0, 16'h0A00, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      push_exp(3'b010, 32'hA5A5_0A01, 2'd1, 16'h0A01, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      push_exp(3'b100, 32'hA5A5_0A02, 2'd2, 16'h0A02, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      issue(0, 16'h0A00, 1'b0, 32'h0, 4'hF, 2);
      issue(1, 16'h0A01, 1'b0, 32'h0, 4'hF, 2);
      issue(2, 16'h0A02, 1'b0, 32'h0, 4'hF, 2);
      wait_done("rr_order");

      // Master 0 read with 2-cycle slave; check 1-cycle arbitration latency
      slave_lat = 2;
      push_exp(3'b001, 32'hA5A5_0100, 2'd0, 16'h0100, 1'b0, 32'h0, 4'h3, 1'b1, 1'b0);
      issue(0, 16'h0100, 1'b0, 32'h0, 4'h3, 1);
      n = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge wb_clk_i);
         if (s_wb_stb_i[0]) begin
            n = 1;
            break;
         end
      end
      chk("m0_stb_seen", 64'(n), 64'd1);
      chk("arb_cycle_mstb", 64'(m_wb_stb_o), 64'd0);
      @(negedge wb_clk_i);
      chk("busy_mstb", 64'(m_wb_stb_o), 64'd1);
      chk("busy_adr",  64'(m_wb_adr_o), 64'h0100);
      wait_done("m0_read");

      // Master 1 write while master 2 idle
      slave_lat = 1;
      push_exp(3'b010, 32'hA5A5_1001, 2'd1, 16'h1001, 1'b1, 32'h5, 4'hF, 1'b1, 1'b0);
      issue(1, 16'h1001, 1'b1, 32'h5, 4'hF, 1);
      wait_done("m1_write");

`ifdef JELLY2_RTOS_WB_ARB_TIMEOUT_EN
      // Slave never acks: forced completion on the 16th BUSY cycle
      slave_mute = 1'b1;
      push_exp(3'b100, 32'hDEAD_0BAD, 2'd2, 16'h2002, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
      issue(2, 16'h2002, 1'b0, 32'h0, 4'hF, 1);
      wait_mstb("tmo_start");
      n = 1;
      while (!(|s_wb_ack_o) && n < 40) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk("tmo_cycle", 64'(n), 64'd16);
      wait_done("tmo");
      slave_mute = 1'b0;
`endif

      // Master drops stb before ack: no ack, arbiter returns to IDLE
      slave_mute = 1'b1;
      issue(2, 16'h2200, 1'b0, 32'h0, 4'hF, 1);
      wait_mstb("drop_start");
      chk("drop_id", 64'(m_wb_id_o), 64'd2);
      @(posedge wb_clk_i);
      #3 rem[2] = 0;
      @(posedge wb_clk_i);
      #3;
      chk("drop_mstb", 64'(m_wb_stb_o), 64'd0);
      chk("drop_ack",  64'(s_wb_ack_o), 64'd0);
      repeat (2) @(negedge wb_clk_i);
      chk("drop_idle_mstb", 64'(m_wb_stb_o), 64'd0);
      slave_mute = 1'b0;

      // Make master 0 the last served so a lost reset of 'last' would favour master 1
      push_exp(3'b001, 32'hA5A5_0300, 2'd0, 16'h0300, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      issue(0, 16'h0300, 1'b0, 32'h0, 4'hF, 1);
      wait_done("pre_reset");

      // Reset while master 1 is in BUSY
      slave_mute = 1'b1;
      issue(1, 16'h1100, 1'b0, 32'h0, 4'hF, 1);
      wait_mstb("rst_busy_start");
      chk("rst_busy_id", 64'(m_wb_id_o), 64'd1);
      #1 wb_rst_i = 1'b0;
      #1;
      chk("rst_busy_mstb", 64'(m_wb_stb_o), 64'd0);
      chk("rst_busy_ack",  64'(s_wb_ack_o), 64'd0);
      chk("rst_busy_id0",  64'(m_wb_id_o), 64'd0);
      push_exp(3'b001, 32'hA5A5_0301, 2'd0, 16'h0301, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      push_exp(3'b010, 32'hA5A5_1100, 2'd1, 16'h1100, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      issue(0, 16'h0301, 1'b0, 32'h0, 4'hF, 1);
      repeat (2) @(posedge wb_clk_i);
      #3 wb_rst_i = 1'b1;
      slave_mute = 1'b0;
      wait_done("post_reset");

      repeat (5) @(negedge wb_clk_i);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
